demux_stream: RTL and testbench

Registered 1-to-N stream demultiplexer: the receiving end of the team's mux datapath, steering one `valid`/`ready` input stream to one of `N_OUT` output channels selected per beat. Each channel has a one-entry output register, so a stalled channel holds only its own slot. Inputs whose select is out of range are accepted, discarded and counted. Sits downstream of `mux_2`-style selectors wherever a shared bus is fanned back out to per-consumer lanes.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_stream_if.sv | 28 ++
 rtl/demux_slot.sv | 47 ++++
 rtl/demux_stream.sv | 74 +++++++
 tb/tb_demux_stream.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    localparam int DROP_CNT_W = 8;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/demux_stream_if.sv
// Input stream plus fanned-out per-channel streams of the demultiplexer.
interface demux_stream_if #(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
    import demux_pkg::*;

    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic                   in_valid;
    logic                   in_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [DROP_CNT_W-1:0]  drop_cnt;

    modport master (
        output in_data, in_sel, in_valid, out_ready,
        input  in_ready, out_data, out_valid, drop_cnt
    );

    modport slave (
        input  in_data, in_sel, in_valid, out_ready,
        output in_ready, out_data, out_valid, drop_cnt
    );

endinterface

// File: rtl/demux_slot.sv
// One output channel: EMPTY/FULL slot, visible 1 cycle after push.
// Accepts a push while empty or while its consumer pops in the same cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    slot_state_e      state_q;
    slot_state_e      state_d;
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                data_q <= push_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (push) state_d = FULL;
            FULL:  if (pop_ready && !push) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign valid      = (state_q == FULL);
    assign data       = data_q;
    assign can_accept = (state_q == EMPTY) || pop_ready;

endmodule

// File: rtl/demux_stream.sv
// Registered 1-to-N demux, 1-cycle latency; stalls input only for a full, non-ready target.
// Out-of-range selects are always accepted, discarded and counted (saturating).
module demux_stream
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    demux_stream_if.slave  bus
);

    logic [N_OUT-1:0]       push;
    logic [N_OUT-1:0]       can_accept;
    logic [N_OUT-1:0]       slot_valid;
    logic [WIDTH-1:0]       slot_data [N_OUT];
    logic [N_OUT*WIDTH-1:0] out_data_w;
    logic                   in_range;
    logic                   sel_ok;
    logic                   in_ready_w;
    logic                   xfer;
    logic [DROP_CNT_W-1:0]  drop_q;

    assign in_range = sel_in_range(32'(bus.in_sel), N_OUT);

    // Ready mux never looks at in_valid, so upstream may wait on in_ready.
    always_comb begin
        sel_ok = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (bus.in_sel == SEL_W'(k)) sel_ok = can_accept[k];
        end
    end

    assign in_ready_w = !in_range || sel_ok;
    assign xfer       = bus.in_valid && in_ready_w;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign push[k] = xfer && in_range && (bus.in_sel == SEL_W'(k));

        demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push[k]),
            .push_data  (bus.in_data),
            .pop_ready  (bus.out_ready[k]),
            .valid      (slot_valid[k]),
            .data       (slot_data[k]),
            .can_accept (can_accept[k])
        );
    end

    always_comb begin
        out_data_w = '0;
        for (int k = 0; k < N_OUT; k++) begin
            out_data_w[k*WIDTH +: WIDTH] = slot_data[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (xfer && !in_range && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = slot_valid;
    assign bus.out_data  = out_data_w;
    assign bus.drop_cnt  = drop_q;

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench: a 4-channel instance for routing/stall/reset, a 3-channel one for drops.
module tb_demux_stream;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    demux_stream_if #(.WIDTH(8), .N_OUT(4)) bus4 ();
    demux_stream_if #(.WIDTH(8), .N_OUT(3)) bus3 ();

    demux_stream #(.WIDTH(8), .N_OUT(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    demux_stream #(.WIDTH(8), .N_OUT(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic beat4(input logic [1:0] sel, input logic [7:0] dat);
        bus4.in_valid = 1'b1;
        bus4.in_sel   = sel;
        bus4.in_data  = dat;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Reset held with random inputs on both instances
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus4.in_valid  = 1'($urandom);
            bus4.in_sel    = 2'($urandom);
            bus4.in_data   = 8'($urandom);
            bus4.out_ready = 4'($urandom);
            bus3.in_valid  = 1'($urandom);
            bus3.in_sel    = 2'($urandom);
            bus3.in_data   = 8'($urandom);
            bus3.out_ready = 3'($urandom);
        end
        @(negedge clk);
        chk("rst_vld4", 32'(bus4.out_valid), 32'h0);
        chk("rst_dat4", 32'(bus4.out_data), 32'h0);
        chk("rst_drop4", 32'(bus4.drop_cnt), 32'h0);
        chk("rst_vld3", 32'(bus3.out_valid), 32'h0);
        chk("rst_drop3", 32'(bus3.drop_cnt), 32'h0);

        rst_n          = 1'b1;
        bus4.in_valid  = 1'b0;
        bus4.in_sel    = 2'd0;
        bus4.in_data   = 8'h00;
        bus4.out_ready = 4'hF;
        bus3.in_valid  = 1'b0;
        bus3.in_sel    = 2'd0;
        bus3.in_data   = 8'h00;
        bus3.out_ready = 3'h7;
        #1;
        chk("rst_rdy4", 32'(bus4.in_ready), 32'h1);

        // Routing: A0..A3 to channels 0..3 back to back
        @(negedge clk);
        beat4(2'd0, 8'hA0);
        #1 chk("route_rdy0", 32'(bus4.in_ready), 32'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("route_vld%0d", i), 32'(bus4.out_valid), 32'(4'b0001 << i));
            chk($sformatf("route_dat%0d", i), 32'(bus4.out_data[i*8 +: 8]), 32'hA0 + 32'(i));
            if (i < 3) begin
                beat4(2'(i + 1), 8'(8'hA1 + i));
                #1 chk($sformatf("route_rdy%0d", i + 1), 32'(bus4.in_ready), 32'h1);
            end else begin
                bus4.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("route_drain", 32'(bus4.out_valid), 32'h0);

        // Back-pressure on channel 2
        bus4.out_ready = 4'b1011;
        beat4(2'd2, 8'h11);
        #1 chk("bp_rdy_first", 32'(bus4.in_ready), 32'h1);
        @(negedge clk);
        chk("bp_vld_11", 32'(bus4.out_valid), 32'b0100);
        chk("bp_dat_11", 32'(bus4.out_data[23:16]), 32'h11);
        beat4(2'd2, 8'h22);
        #1 chk("bp_rdy_stall", 32'(bus4.in_ready), 32'h0);
        @(negedge clk);
        chk("bp_hold_dat", 32'(bus4.out_data[23:16]), 32'h11);
        chk("bp_hold_vld", 32'(bus4.out_valid), 32'b0100);
        bus4.out_ready = 4'hF;
        #1 chk("bp_rdy_release", 32'(bus4.in_ready), 32'h1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        chk("bp_vld_22", 32'(bus4.out_valid), 32'b0100);
        chk("bp_dat_22", 32'(bus4.out_data[23:16]), 32'h22);
        @(negedge clk);
        chk("bp_drain", 32'(bus4.out_valid), 32'h0);

        // Independence: channel 1 stalled, channel 3 still flows
        bus4.out_ready = 4'b1101;
        beat4(2'd1, 8'h55);
        @(negedge clk);
        chk("ind_vld1", 32'(bus4.out_valid), 32'b0010);
        beat4(2'd3, 8'h77);
        #1 chk("ind_rdy3", 32'(bus4.in_ready), 32'h1);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        chk("ind_vld13", 32'(bus4.out_valid), 32'b1010);
        chk("ind_dat3", 32'(bus4.out_data[31:24]), 32'h77);
        chk("ind_dat1", 32'(bus4.out_data[15:8]), 32'h55);
        beat4(2'd1, 8'h66);
        #1 chk("ind_rdy1_stall", 32'(bus4.in_ready), 32'h0);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        chk("ind_vld_after", 32'(bus4.out_valid), 32'b0010);
        chk("ind_dat1_kept", 32'(bus4.out_data[15:8]), 32'h55);
        bus4.out_ready = 4'hF;
        @(negedge clk);
        chk("ind_drain", 32'(bus4.out_valid), 32'h0);

        // Drops on the 3-channel instance
        bus3.in_valid = 1'b1;
        bus3.in_sel   = 2'd3;
        for (int i = 0; i < 300; i++) begin
            bus3.in_data = 8'($urandom);
            #1;
            chk("drop_rdy", 32'(bus3.in_ready), 32'h1);
            chk("drop_vld", 32'(bus3.out_valid), 32'h0);
            chk("drop_cnt", 32'(bus3.drop_cnt), (i > 255) ? 32'd255 : 32'(i));
            @(negedge clk);
        end
        bus3.in_valid = 1'b0;
        chk("drop_sat", 32'(bus3.drop_cnt), 32'd255);
        chk("drop_vld_end", 32'(bus3.out_valid), 32'h0);
        chk("drop_none4", 32'(bus4.drop_cnt), 32'h0);

        // Mid-operation asynchronous reset with channels 0 and 2 full
        bus4.out_ready = 4'h0;
        beat4(2'd0, 8'h01);
        @(negedge clk);
        beat4(2'd2, 8'h02);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        chk("mid_vld_pre", 32'(bus4.out_valid), 32'b0101);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_vld_async", 32'(bus4.out_valid), 32'h0);
        chk("mid_dat_async", 32'(bus4.out_data), 32'h0);
        chk("mid_drop_async", 32'(bus3.drop_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mid_rdy_after", 32'(bus4.in_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
